imm_inst_encoder: RTL and testbench

- Inverse of the datapath immediate extender: accepts decoded instruction fields plus a signed 32-bit immediate and format select, range-checks the immediate, scatters its bits into the RV32 instruction word per format, and streams the packed word with a sequential write address toward instruction memory.
- Used by the program-loader / self-test path of the multicycle processor to build instruction memory images in-system.
- One-deep registered output stage with valid/ready handshakes on both sides.

---
 rtl/imm_inst_encoder_pkg.sv | 36 +++
 rtl/imm_inst_encoder_imm_pack.sv | 70 +++++++
 rtl/imm_inst_encoder.sv | 119 +++++++++++
 tb/tb_imm_inst_encoder.sv | 317 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/imm_inst_encoder_pkg.sv
// Shared definitions for the immediate instruction encoder.
// Holds the immediate-format codes (same coding as the datapath extender's
// ImmSrc), RV32 field bit positions, the opcodes used by the loader/self-test,
// and a small sign-range helper used by the packer.
package imm_inst_encoder_pkg;

  // Immediate format select; must match the extender's ImmSrc coding.
  typedef enum logic [1:0] {
    FMT_I = 2'b00,
    FMT_B = 2'b01,
    FMT_S = 2'b10,
    FMT_J = 2'b11
  } imm_fmt_e;

  // RV32 base field positions (LSB of each field).
  localparam int unsigned OPC_LSB = 0;
  localparam int unsigned RD_LSB  = 7;
  localparam int unsigned F3_LSB  = 12;
  localparam int unsigned RS1_LSB = 15;
  localparam int unsigned RS2_LSB = 20;

  // Opcodes exercised by the loader / self-test images.
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;

  // True when imm[31:lo] are all equal, i.e. the value fits a signed field
  // whose sign bit sits at position lo.
  function automatic logic fits_signed(input logic [31:0] imm, input int unsigned lo);
    logic [31:0] upper;
    upper = 32'($signed(imm) >>> lo);
    return (upper == 32'h0000_0000) || (upper == 32'hFFFF_FFFF);
  endfunction

endpackage

// File: rtl/imm_inst_encoder_imm_pack.sv
// imm_pack: combinational scatter of a signed immediate plus decoded fields
// into an RV32 instruction word, with a range/alignment legality flag.
// Ports:
//   fmt_i    format select (FMT_I/B/S/J)
//   imm_i    signed immediate (byte offset for B/J)
//   opcode_i, rd_i, funct3_i, rs1_i, rs2_i  decoded fields
//   inst_o   packed instruction (fields unused by the format are 0)
//   legal_o  immediate is representable in the selected format
module imm_pack
  import imm_inst_encoder_pkg::*;
(
  input  logic [1:0]  fmt_i,
  input  logic [31:0] imm_i,
  input  logic [6:0]  opcode_i,
  input  logic [4:0]  rd_i,
  input  logic [2:0]  funct3_i,
  input  logic [4:0]  rs1_i,
  input  logic [4:0]  rs2_i,
  output logic [31:0] inst_o,
  output logic        legal_o
);

  // Field scatter and legality per format.
  always_comb begin
    inst_o  = 32'h0000_0000;
    legal_o = 1'b0;
    inst_o[OPC_LSB +: 7] = opcode_i;
    case (fmt_i)
      FMT_I: begin
        inst_o[31:20]        = imm_i[11:0];
        inst_o[RS1_LSB +: 5] = rs1_i;
        inst_o[F3_LSB +: 3]  = funct3_i;
        inst_o[RD_LSB +: 5]  = rd_i;
        legal_o              = fits_signed(imm_i, 11);
      end
      FMT_S: begin
        inst_o[31:25]        = imm_i[11:5];
        inst_o[RS2_LSB +: 5] = rs2_i;
        inst_o[RS1_LSB +: 5] = rs1_i;
        inst_o[F3_LSB +: 3]  = funct3_i;
        inst_o[11:7]         = imm_i[4:0];
        legal_o              = fits_signed(imm_i, 11);
      end
      FMT_B: begin
        inst_o[31]           = imm_i[12];
        inst_o[30:25]        = imm_i[10:5];
        inst_o[RS2_LSB +: 5] = rs2_i;
        inst_o[RS1_LSB +: 5] = rs1_i;
        inst_o[F3_LSB +: 3]  = funct3_i;
        inst_o[11:8]         = imm_i[4:1];
        inst_o[7]            = imm_i[11];
        // Branch offsets are halfword aligned; bit 0 is not encodable.
        legal_o              = fits_signed(imm_i, 12) & ~imm_i[0];
      end
      FMT_J: begin
        inst_o[31]           = imm_i[20];
        inst_o[30:21]        = imm_i[10:1];
        inst_o[20]           = imm_i[11];
        inst_o[19:12]        = imm_i[19:12];
        inst_o[RD_LSB +: 5]  = rd_i;
        legal_o              = fits_signed(imm_i, 20) & ~imm_i[0];
      end
      default: begin
        inst_o  = 32'h0000_0000;
        legal_o = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/imm_inst_encoder.sv
// imm_inst_encoder: builds RV32 instruction words from decoded fields and an
// immediate, and streams them with sequential word addresses toward
// instruction memory through a one-deep registered output stage.
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   in_valid/in_ready          request handshake
//   in_fmt, in_opcode, in_rd, in_funct3, in_rs1, in_rs2, in_imm  request fields
//   out_valid/out_ready        packed-word handshake
//   out_inst, out_addr         packed word and its word address
//   err_pulse                  one-cycle flag: previous accepted request rejected
//   err_count                  saturating count of rejected requests
module imm_inst_encoder
  import imm_inst_encoder_pkg::*;
#(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DEPTH  = 256,
  parameter int unsigned ERR_W  = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        in_fmt,
  input  logic [6:0]        in_opcode,
  input  logic [4:0]        in_rd,
  input  logic [2:0]        in_funct3,
  input  logic [4:0]        in_rs1,
  input  logic [4:0]        in_rs2,
  input  logic [31:0]       in_imm,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_inst,
  output logic [ADDR_W-1:0] out_addr,
  output logic              err_pulse,
  output logic [ERR_W-1:0]  err_count
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  logic [31:0]       pack_inst_s;
  logic              pack_legal_s;
  logic              accept_s;

  logic              out_valid_q, out_valid_d;
  logic [31:0]       out_inst_q, out_inst_d;
  logic [ADDR_W-1:0] out_addr_q, out_addr_d;
  logic [ADDR_W-1:0] next_addr_q, next_addr_d;
  logic              err_pulse_q, err_pulse_d;
  logic [ERR_W-1:0]  err_count_q, err_count_d;

  imm_pack u_pack (
    .fmt_i    (in_fmt),
    .imm_i    (in_imm),
    .opcode_i (in_opcode),
    .rd_i     (in_rd),
    .funct3_i (in_funct3),
    .rs1_i    (in_rs1),
    .rs2_i    (in_rs2),
    .inst_o   (pack_inst_s),
    .legal_o  (pack_legal_s)
  );

  // The stage can take a new word when empty or when its word retires now.
  assign in_ready = ~reset & (~out_valid_q | out_ready);
  assign accept_s = in_valid & in_ready;

  // Next-state for output stage, address counter and error tracking.
  always_comb begin
    out_valid_d = out_valid_q;
    out_inst_d  = out_inst_q;
    out_addr_d  = out_addr_q;
    next_addr_d = next_addr_q;
    err_pulse_d = accept_s & ~pack_legal_s;
    err_count_d = err_count_q;
    if (accept_s && pack_legal_s) begin
      // Covers load-into-empty and retire-and-reload in the same cycle.
      out_valid_d = 1'b1;
      out_inst_d  = pack_inst_s;
      out_addr_d  = next_addr_q;
      next_addr_d = (next_addr_q == LAST_ADDR) ? {ADDR_W{1'b0}} : next_addr_q + ADDR_W'(1);
    end else if (out_ready) begin
      // Rejected requests consume the slot but never produce a word.
      out_valid_d = 1'b0;
    end else begin
      out_valid_d = out_valid_q;
    end
    if (accept_s && !pack_legal_s && (err_count_q != {ERR_W{1'b1}})) begin
      err_count_d = err_count_q + ERR_W'(1);
    end else begin
      err_count_d = err_count_q;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid_q <= 1'b0;
      out_inst_q  <= 32'h0000_0000;
      out_addr_q  <= {ADDR_W{1'b0}};
      next_addr_q <= {ADDR_W{1'b0}};
      err_pulse_q <= 1'b0;
      err_count_q <= {ERR_W{1'b0}};
    end else begin
      out_valid_q <= out_valid_d;
      out_inst_q  <= out_inst_d;
      out_addr_q  <= out_addr_d;
      next_addr_q <= next_addr_d;
      err_pulse_q <= err_pulse_d;
      err_count_q <= err_count_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_inst  = out_inst_q;
  assign out_addr  = out_addr_q;
  assign err_pulse = err_pulse_q;
  assign err_count = err_count_q;

endmodule

// File: tb/tb_imm_inst_encoder.sv
// Self-checking bench for imm_inst_encoder: directed test-plan vectors, error
// handling, backpressure, randomized traffic, saturation and a DEPTH=4 wrap.
module tb_imm_inst_encoder;
  import imm_inst_encoder_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [1:0]  in_fmt = 2'd0;
  logic [6:0]  in_opcode = 7'd0;
  logic [4:0]  in_rd = 5'd0, in_rs1 = 5'd0, in_rs2 = 5'd0;
  logic [2:0]  in_funct3 = 3'd0;
  logic [31:0] in_imm = 32'd0;

  logic        in_ready, out_valid, err_pulse;
  logic [31:0] out_inst;
  logic [7:0]  out_addr, err_count;
  logic        in_ready4, out_valid4, err_pulse4;
  logic [31:0] out_inst4;
  logic [7:0]  out_addr4, err_count4;

  int n_checks = 0;
  int n_fail = 0;

  // Reference model state (transaction level).
  bit          exp_valid;
  logic [31:0] exp_inst, exp_imm;
  logic [1:0]  exp_fmt;
  int          exp_addr, exp_next, exp_addr4, exp_next4, exp_cnt;
  bit          exp_pulse;

  always #5 clk = ~clk;

  imm_inst_encoder #(.ADDR_W(8), .DEPTH(256), .ERR_W(8)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_fmt(in_fmt), .in_opcode(in_opcode), .in_rd(in_rd), .in_funct3(in_funct3),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm),
    .out_valid(out_valid), .out_ready(out_ready), .out_inst(out_inst),
    .out_addr(out_addr), .err_pulse(err_pulse), .err_count(err_count));

  imm_inst_encoder #(.ADDR_W(8), .DEPTH(4), .ERR_W(8)) dut4 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready4),
    .in_fmt(in_fmt), .in_opcode(in_opcode), .in_rd(in_rd), .in_funct3(in_funct3),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm),
    .out_valid(out_valid4), .out_ready(out_ready), .out_inst(out_inst4),
    .out_addr(out_addr4), .err_pulse(err_pulse4), .err_count(err_count4));

  // Legality from the numeric range each format can encode.
  function automatic bit model_legal(input logic [1:0] f, input logic [31:0] imm);
    longint v;
    v = longint'($signed(imm));
    case (f)
      FMT_I, FMT_S: return (v >= -2048) && (v <= 2047);
      FMT_B:        return (v >= -4096) && (v <= 4095) && (v % 2 == 0);
      default:      return (v >= -1048576) && (v <= 1048575) && (v % 2 == 0);
    endcase
  endfunction

  // Instruction word built by arithmetic shifts/masks of the immediate.
  function automatic logic [31:0] model_pack(input logic [1:0] f, input logic [6:0] op,
      input logic [4:0] rd, input logic [2:0] f3, input logic [4:0] rs1,
      input logic [4:0] rs2, input logic [31:0] u);
    logic [31:0] w;
    w = 32'(op);
    case (f)
      FMT_I: w = w | ((u & 32'hFFF) << 20) | (32'(rs1) << 15) | (32'(f3) << 12) | (32'(rd) << 7);
      FMT_S: w = w | (((u >> 5) & 32'h7F) << 25) | (32'(rs2) << 20) | (32'(rs1) << 15)
                   | (32'(f3) << 12) | ((u & 32'h1F) << 7);
      FMT_B: w = w | (((u >> 12) & 32'h1) << 31) | (((u >> 5) & 32'h3F) << 25)
                   | (32'(rs2) << 20) | (32'(rs1) << 15) | (32'(f3) << 12)
                   | (((u >> 1) & 32'hF) << 8) | (((u >> 11) & 32'h1) << 7);
      default: w = w | (((u >> 20) & 32'h1) << 31) | (((u >> 1) & 32'h3FF) << 21)
                   | (((u >> 11) & 32'h1) << 20) | (((u >> 12) & 32'hFF) << 12) | (32'(rd) << 7);
    endcase
    return w;
  endfunction

  // The datapath extender, used to check the round-trip property.
  function automatic logic [31:0] extend(input logic [31:0] i, input logic [1:0] f);
    case (f)
      FMT_I:   return {{20{i[31]}}, i[31:20]};
      FMT_S:   return {{20{i[31]}}, i[31:25], i[11:7]};
      FMT_B:   return {{20{i[31]}}, i[7], i[30:25], i[11:8], 1'b0};
      default: return {{12{i[31]}}, i[19:12], i[20], i[30:21], 1'b0};
    endcase
  endfunction

  function automatic logic [31:0] rand_imm(input logic [1:0] f, input bit legal);
    logic [31:0] r;
    r = $urandom;
    if (!legal) begin
      while (model_legal(f, r)) r = $urandom;
      return r;
    end
    if ($urandom_range(0, 7) == 0) begin
      case (f)
        FMT_I, FMT_S: r = r[0] ? 32'h0000_07FF : 32'hFFFF_F800;
        FMT_B:        r = r[0] ? 32'h0000_0FFE : 32'hFFFF_F000;
        default:      r = r[0] ? 32'h000F_FFFE : 32'hFFF0_0000;
      endcase
      return r;
    end
    case (f)
      FMT_I, FMT_S: return {{20{r[11]}}, r[11:0]};
      FMT_B:        return {{19{r[12]}}, r[12:1], 1'b0};
      default:      return {{11{r[20]}}, r[20:1], 1'b0};
    endcase
  endfunction

  // Advance the reference model by one clock using the inputs in force.
  task automatic model_edge();
    bit acc, lg;
    if (reset) begin
      exp_valid = 0; exp_inst = 32'd0; exp_addr = 0; exp_next = 0;
      exp_addr4 = 0; exp_next4 = 0; exp_cnt = 0; exp_pulse = 0;
    end else begin
      acc = in_valid && (!exp_valid || out_ready);
      lg  = model_legal(in_fmt, in_imm);
      exp_pulse = acc && !lg;
      if (acc && !lg && exp_cnt < 255) exp_cnt++;
      if (acc && lg) begin
        exp_valid = 1;
        exp_inst  = model_pack(in_fmt, in_opcode, in_rd, in_funct3, in_rs1, in_rs2, in_imm);
        exp_fmt   = in_fmt;
        exp_imm   = in_imm;
        exp_addr  = exp_next;  exp_next  = (exp_next + 1) % 256;
        exp_addr4 = exp_next4; exp_next4 = (exp_next4 + 1) % 4;
      end else if (out_ready) begin
        exp_valid = 0;
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic drive(input logic [1:0] f, input logic [6:0] op, input logic [4:0] rd,
      input logic [2:0] f3, input logic [4:0] rs1, input logic [4:0] rs2, input logic [31:0] imm);
    in_valid = 1'b1; in_fmt = f; in_opcode = op; in_rd = rd;
    in_funct3 = f3; in_rs1 = rs1; in_rs2 = rs2; in_imm = imm;
  endtask

  task automatic drive_rand(input bit legal);
    logic [1:0] f;
    f = 2'($urandom_range(0, 3));
    drive(f, 7'($urandom), 5'($urandom), 3'($urandom), 5'($urandom), 5'($urandom), rand_imm(f, legal));
  endtask

  task automatic test_reset();
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    step(); step();
    #1;
    n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL reset_in_ready: got %b want 0", in_ready); end
    n_checks++; if (out_valid !== 1'b0 || out_valid4 !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b/%b want 0", out_valid, out_valid4); end
    n_checks++; if (out_inst !== 32'd0 || out_addr !== 8'd0) begin n_fail++; $display("FAIL reset_inst_addr: got %h/%0d want 0/0", out_inst, out_addr); end
    n_checks++; if (err_pulse !== 1'b0 || err_count !== 8'd0) begin n_fail++; $display("FAIL reset_err: got %b/%0d want 0/0", err_pulse, err_count); end
    reset = 1'b0;
    #1;
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL post_reset_in_ready: got %b want 1", in_ready); end
  endtask

  task automatic test_directed();
    logic [31:0] want [4];
    want[0] = 32'hFFF00293; want[1] = 32'h00208463; want[2] = 32'h00512623; want[3] = 32'h001000EF;
    out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      case (k)
        0: drive(FMT_I, OPC_OP_IMM, 5'd5, 3'd0, 5'd0, 5'd0, 32'hFFFF_FFFF);
        1: drive(FMT_B, OPC_BRANCH, 5'd0, 3'd0, 5'd1, 5'd2, 32'd8);
        2: drive(FMT_S, OPC_STORE,  5'd0, 3'd2, 5'd2, 5'd5, 32'd12);
        default: drive(FMT_J, OPC_JAL, 5'd1, 3'd0, 5'd0, 5'd0, 32'h0000_0800);
      endcase
      step();
      n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL directed_valid[%0d]: got %b want 1", k, out_valid); end
      n_checks++; if (out_inst !== want[k]) begin n_fail++; $display("FAIL directed_inst[%0d]: got %h want %h", k, out_inst, want[k]); end
      n_checks++; if (out_addr !== 8'(k)) begin n_fail++; $display("FAIL directed_addr[%0d]: got %0d want %0d", k, out_addr, k); end
      n_checks++; if (extend(out_inst, in_fmt) !== in_imm) begin n_fail++; $display("FAIL directed_roundtrip[%0d]: got %h want %h", k, extend(out_inst, in_fmt), in_imm); end
    end
    in_valid = 1'b0;
    step();
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL directed_drain: got %b want 0", out_valid); end
  endtask

  task automatic test_errors();
    out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      case (k)
        0: drive(FMT_B, OPC_BRANCH, 5'd0, 3'd0, 5'd1, 5'd2, 32'd3);
        1: drive(FMT_I, OPC_OP_IMM, 5'd1, 3'd0, 5'd1, 5'd0, 32'd2048);
        default: drive(FMT_J, OPC_JAL, 5'd1, 3'd0, 5'd0, 5'd0, 32'h0010_0000);
      endcase
      step();
      n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL err_no_output[%0d]: got %b want 0", k, out_valid); end
      n_checks++; if (err_pulse !== 1'b1) begin n_fail++; $display("FAIL err_pulse[%0d]: got %b want 1", k, err_pulse); end
      n_checks++; if (err_count !== 8'(k + 1)) begin n_fail++; $display("FAIL err_count[%0d]: got %0d want %0d", k, err_count, k + 1); end
    end
    in_valid = 1'b0;
    step();
    n_checks++; if (err_pulse !== 1'b0 || err_count !== 8'd3) begin n_fail++; $display("FAIL err_pulse_drop: got %b/%0d want 0/3", err_pulse, err_count); end
    drive(FMT_I, OPC_OP_IMM, 5'd3, 3'd0, 5'd3, 5'd0, 32'd5);
    step();
    n_checks++; if (out_valid !== 1'b1 || out_addr !== 8'd4) begin n_fail++; $display("FAIL err_addr_hold: got %b/%0d want 1/4", out_valid, out_addr); end
    in_valid = 1'b0;
  endtask

  task automatic test_backpressure();
    logic [31:0] held_inst;
    logic [7:0]  held_addr, prev_addr;
    out_ready = 1'b1;
    drive_rand(1'b1);
    step();
    held_inst = out_inst; held_addr = out_addr;
    n_checks++; if (out_inst !== exp_inst) begin n_fail++; $display("FAIL bp_first: got %h want %h", out_inst, exp_inst); end
    out_ready = 1'b0;
    drive_rand(1'b1);
    for (int k = 0; k < 3; k++) begin
      #1;
      n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_in_ready[%0d]: got %b want 0", k, in_ready); end
      step();
      n_checks++; if (out_valid !== 1'b1 || out_inst !== held_inst || out_addr !== held_addr) begin
        n_fail++; $display("FAIL bp_hold[%0d]: got %b/%h/%0d want 1/%h/%0d", k, out_valid, out_inst, out_addr, held_inst, held_addr); end
    end
    out_ready = 1'b1;
    prev_addr = held_addr;
    for (int k = 0; k < 4; k++) begin
      step();
      n_checks++; if (out_valid !== 1'b1 || out_inst !== exp_inst || out_addr !== 8'(prev_addr + 8'd1)) begin
        n_fail++; $display("FAIL bp_stream[%0d]: got %b/%h/%0d want 1/%h/%0d", k, out_valid, out_inst, out_addr, exp_inst, 8'(prev_addr + 8'd1)); end
      prev_addr = out_addr;
      drive_rand(1'b1);
    end
    in_valid = 1'b0;
    step();
  endtask

  task automatic test_random();
    for (int k = 0; k < 400; k++) begin
      out_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 4) != 0) drive_rand($urandom_range(0, 4) != 0);
      else in_valid = 1'b0;
      #1;
      n_checks++; if (in_ready !== (!exp_valid || out_ready)) begin n_fail++; $display("FAIL rand_in_ready[%0d]: got %b want %b", k, in_ready, (!exp_valid || out_ready)); end
      step();
      n_checks++; if (out_valid !== exp_valid) begin n_fail++; $display("FAIL rand_valid[%0d]: got %b want %b", k, out_valid, exp_valid); end
      if (exp_valid) begin
        n_checks++; if (out_inst !== exp_inst || out_addr !== 8'(exp_addr)) begin n_fail++; $display("FAIL rand_word[%0d]: got %h@%0d want %h@%0d", k, out_inst, out_addr, exp_inst, exp_addr); end
        n_checks++; if (extend(out_inst, exp_fmt) !== exp_imm) begin n_fail++; $display("FAIL rand_roundtrip[%0d]: got %h want %h", k, extend(out_inst, exp_fmt), exp_imm); end
      end
      n_checks++; if (err_pulse !== exp_pulse || err_count !== 8'(exp_cnt)) begin n_fail++; $display("FAIL rand_err[%0d]: got %b/%0d want %b/%0d", k, err_pulse, err_count, exp_pulse, exp_cnt); end
    end
    in_valid = 1'b0; out_ready = 1'b1;
    step();
  endtask

  task automatic test_saturate();
    out_ready = 1'b1;
    for (int k = 0; k < 260; k++) begin
      drive(FMT_I, OPC_OP_IMM, 5'd1, 3'd0, 5'd1, 5'd0, 32'h0000_1000);
      step();
    end
    n_checks++; if (err_count !== 8'hFF || err_count !== 8'(exp_cnt)) begin n_fail++; $display("FAIL err_saturate: got %0d want 255", err_count); end
    n_checks++; if (err_pulse !== 1'b1) begin n_fail++; $display("FAIL err_saturate_pulse: got %b want 1", err_pulse); end
    in_valid = 1'b0;
    step();
  endtask

  task automatic test_wrap_and_reset();
    logic [7:0] want4 [5];
    want4[0] = 8'd0; want4[1] = 8'd1; want4[2] = 8'd2; want4[3] = 8'd3; want4[4] = 8'd0;
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    step();
    reset = 1'b0;
    for (int k = 0; k < 5; k++) begin
      drive_rand(1'b1);
      step();
      n_checks++; if (out_valid4 !== 1'b1 || out_addr4 !== want4[k] || out_addr4 !== 8'(exp_addr4)) begin
        n_fail++; $display("FAIL wrap_addr[%0d]: got %b/%0d want 1/%0d", k, out_valid4, out_addr4, want4[k]); end
      n_checks++; if (out_inst4 !== exp_inst) begin n_fail++; $display("FAIL wrap_inst[%0d]: got %h want %h", k, out_inst4, exp_inst); end
    end
    // Error then reset mid-stream: counter and pending word must clear.
    drive(FMT_B, OPC_BRANCH, 5'd0, 3'd0, 5'd1, 5'd1, 32'd1);
    step();
    n_checks++; if (err_count4 !== 8'd1 || err_pulse4 !== 1'b1) begin n_fail++; $display("FAIL wrap_err: got %0d/%b want 1/1", err_count4, err_pulse4); end
    drive_rand(1'b1);
    reset = 1'b1;
    #1;
    n_checks++; if (in_ready !== 1'b0 || in_ready4 !== 1'b0) begin n_fail++; $display("FAIL midreset_in_ready: got %b/%b want 0", in_ready, in_ready4); end
    step();
    n_checks++; if (out_valid !== 1'b0 || out_valid4 !== 1'b0) begin n_fail++; $display("FAIL midreset_valid: got %b/%b want 0", out_valid, out_valid4); end
    n_checks++; if (err_count !== 8'd0 || err_count4 !== 8'd0) begin n_fail++; $display("FAIL midreset_err: got %0d/%0d want 0", err_count, err_count4); end
    reset = 1'b0;
    drive_rand(1'b1);
    step();
    n_checks++; if (out_valid !== 1'b1 || out_addr !== 8'd0 || out_addr4 !== 8'd0) begin
      n_fail++; $display("FAIL midreset_addr: got %b/%0d/%0d want 1/0/0", out_valid, out_addr, out_addr4); end
    n_checks++; if (out_inst !== exp_inst) begin n_fail++; $display("FAIL midreset_inst: got %h want %h", out_inst, exp_inst); end
    in_valid = 1'b0;
    step();
  endtask

  initial begin
    test_reset();
    test_directed();
    test_errors();
    test_backpressure();
    test_random();
    test_saturate();
    test_wrap_and_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
